// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm : multi-cycle main control FSM for the MIPS-subset datapath.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback. opcode/funct come from the instruction register. The FSM
// stalls in the fetch and data-memory states until memReady is high.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   opcode, funct       instr[31:26] and instr[5:0] from the IR
//   memReady            memory completes its access this cycle
//   pcWrite/pcWriteCond PC load (unconditional / on branch condition)
//   branchNe            branch condition select (1 = !zero, 0 = zero)
//   iorD                memory address select (0 = PC, 1 = aluOut)
//   memRead/memWrite    memory strobes, held for the whole wait
//   irWrite             IR load
//   regDst, memToReg    register-file write address / data selects
//   regWrite            register-file write enable
//   aluSrcA, aluSrcB    ALU operand selects
//   pcSource            next-PC select
//   aluOp               operation code for the ALU control decoder
//   illegal             one-cycle pulse on an unsupported opcode/funct
//   state               current state encoding (debug)
//
// Parameter RA_REG is the link register written by jal; the datapath picks
// it when regDst = 2'b10.
//
// Optional build macro MC_CTRL_PERF_CNT_EN adds two 32-bit counters:
//   instrCount  transitions into fetch (completed or aborted instructions)
//   stallCount  cycles spent waiting on memReady
module mc_ctrl_fsm #(
  parameter int RA_REG = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic [2:0] aluOp,
  output logic       illegal,
  output logic [3:0] state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instrCount,
  output logic [31:0] stallCount
`endif
);

  // The link register is fixed by the register-file width.
  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_reg_range
    $error("RA_REG must index one of the 32 registers");
  end

  localparam logic [3:0] S_RST     = 4'b0000;
  localparam logic [3:0] S_FETCH   = 4'b0001;
  localparam logic [3:0] S_DECODE  = 4'b0010;
  localparam logic [3:0] S_MEMADR  = 4'b0011;
  localparam logic [3:0] S_MEMRD   = 4'b0100;
  localparam logic [3:0] S_MEMWB   = 4'b0101;
  localparam logic [3:0] S_MEMWR   = 4'b0110;
  localparam logic [3:0] S_EXEC_R  = 4'b0111;
  localparam logic [3:0] S_ALUWB_R = 4'b1000;
  localparam logic [3:0] S_EXEC_I  = 4'b1001;
  localparam logic [3:0] S_ALUWB_I = 4'b1010;
  localparam logic [3:0] S_BRANCH  = 4'b1011;
  localparam logic [3:0] S_JUMP    = 4'b1100;
  localparam logic [3:0] S_JAL     = 4'b1101;
  localparam logic [3:0] S_JR      = 4'b1110;

  logic [3:0] state_q, state_d;

  // Instruction decode (only consumed in states where the IR is stable)
  logic op_lw, op_sw, op_r, op_beq, op_bne, op_j, op_jal, op_itype, op_known;
  logic funct_jr, funct_ok;

  assign op_lw    = (opcode == 6'b100011);
  assign op_sw    = (opcode == 6'b101011);
  assign op_r     = (opcode == 6'b000000);
  assign op_beq   = (opcode == 6'b000100);
  assign op_bne   = (opcode == 6'b000101);
  assign op_j     = (opcode == 6'b000010);
  assign op_jal   = (opcode == 6'b000011);
  assign op_itype = (opcode inside {6'b001000, 6'b001010, 6'b001100,
                                    6'b001101, 6'b001110});
  assign op_known = op_lw | op_sw | op_r | op_beq | op_bne | op_j | op_jal | op_itype;
  assign funct_jr = (funct == 6'b001000);
  assign funct_ok = (funct inside {6'b000000, 6'b000010, 6'b000011, 6'b000100,
                                   6'b000110, 6'b000111, 6'b100000, 6'b100010,
                                   6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                   6'b101010, 6'b101011});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        if (op_lw || op_sw)       state_d = S_MEMADR;
        else if (op_r)            state_d = funct_jr ? S_JR : S_EXEC_R;
        else if (op_beq || op_bne) state_d = S_BRANCH;
        else if (op_itype)        state_d = S_EXEC_I;
        else if (op_j)            state_d = S_JUMP;
        else if (op_jal)          state_d = S_JAL;
        else                      state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (op_lw)      state_d = S_MEMRD;
        else if (op_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD:  if (memReady) state_d = S_MEMWB;
      S_MEMWR:  if (memReady) state_d = S_FETCH;
      S_EXEC_R: state_d = funct_ok ? S_ALUWB_R : S_FETCH;
      S_EXEC_I: state_d = S_ALUWB_I;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode: Moore except the fetch-time IR/PC loads, which wait for memReady
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchNe    = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 2'b00;
    memToReg    = 2'b00;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    aluOp       = 3'b000;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        illegal = ~op_known;
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 2'b01;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = 3'b110;
        illegal = ~funct_ok;
      end
      S_ALUWB_R: begin
        regWrite = 1'b1;
        regDst   = 2'b01;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        case (opcode)
          6'b001010: aluOp = 3'b101;
          6'b001100: aluOp = 3'b010;
          6'b001101: aluOp = 3'b011;
          6'b001110: aluOp = 3'b100;
          default:   aluOp = 3'b000;
        endcase
      end
      S_ALUWB_I: regWrite = 1'b1;
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 3'b001;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        branchNe    = op_bne;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
      end
      S_JAL: begin
        // PC was already incremented in fetch, so it is the return address
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        regWrite = 1'b1;
        regDst   = 2'b10;
        memToReg = 2'b10;
      end
      S_JR: begin
        pcWrite  = 1'b1;
        pcSource = 2'b11;
      end
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    // Entering fetch from any busy state closes one instruction (incl. aborts)
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
      instr_count_d = instr_count_q + 32'd1;
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !memReady)
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instrCount = instr_count_q;
  assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-instruction phase model with random memReady.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       memReady = 1'b1;
  logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
  logic [1:0] regDst, memToReg, aluSrcB, pcSource;
  logic       regWrite, aluSrcA, illegal;
  logic [2:0] aluOp;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instrCount, stallCount;
`endif

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .pcSource(pcSource), .aluOp(aluOp), .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_CNT_EN
    , .instrCount(instrCount), .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
    logic [1:0] regDst, memToReg;
    logic       regWrite, aluSrcA;
    logic [1:0] aluSrcB, pcSource;
    logic [2:0] aluOp;
    logic       illegal;
    logic [3:0] state;
  } ctl_t;

  int checks = 0;
  int failures = 0;
  int instr_model = 0;
  int stall_model = 0;

  // Expected phase list of the instruction under test
  ctl_t ph_q[$];
  bit   mem_q[$];

  function automatic ctl_t obs();
    return {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, regDst,
            memToReg, regWrite, aluSrcA, aluSrcB, pcSource, aluOp, illegal, state};
  endfunction

  // Phases an instruction walks through, derived from its class
  task automatic build_phases(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    bit is_ld, is_st, is_r, is_br, is_i, known;
    is_ld = (op == 6'h23);
    is_st = (op == 6'h2b);
    is_r  = (op == 6'h00);
    is_br = (op == 6'h04) || (op == 6'h05);
    is_i  = op inside {6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e};
    known = is_ld || is_st || is_r || is_br || is_i || op == 6'h02 || op == 6'h03;
    ph_q.delete(); mem_q.delete();
    c = '0; c.state = 4'd1; c.memRead = 1; c.aluSrcB = 2'b01;
    ph_q.push_back(c); mem_q.push_back(1);
    c = '0; c.state = 4'd2; c.aluSrcB = 2'b11; c.illegal = !known;
    ph_q.push_back(c); mem_q.push_back(0);
    if (!known) return;
    c = '0;
    if (is_ld || is_st) begin
      c.state = 4'd3; c.aluSrcA = 1; c.aluSrcB = 2'b10;
      ph_q.push_back(c); mem_q.push_back(0);
      c = '0; c.iorD = 1;
      if (is_ld) begin c.state = 4'd4; c.memRead = 1; end
      else begin c.state = 4'd6; c.memWrite = 1; end
      ph_q.push_back(c); mem_q.push_back(1);
      if (is_ld) begin
        c = '0; c.state = 4'd5; c.regWrite = 1; c.memToReg = 2'b01;
        ph_q.push_back(c); mem_q.push_back(0);
      end
    end else if (is_r && fn == 6'h08) begin
      c.state = 4'd14; c.pcWrite = 1; c.pcSource = 2'b11;
      ph_q.push_back(c); mem_q.push_back(0);
    end else if (is_r) begin
      c.state = 4'd7; c.aluSrcA = 1; c.aluOp = 3'b110;
      c.illegal = !(fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20,
                               6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b});
      ph_q.push_back(c); mem_q.push_back(0);
      if (!c.illegal) begin
        c = '0; c.state = 4'd8; c.regWrite = 1; c.regDst = 2'b01;
        ph_q.push_back(c); mem_q.push_back(0);
      end
    end else if (is_br) begin
      c.state = 4'd11; c.aluSrcA = 1; c.aluOp = 3'b001; c.pcWriteCond = 1;
      c.pcSource = 2'b01; c.branchNe = (op == 6'h05);
      ph_q.push_back(c); mem_q.push_back(0);
    end else if (is_i) begin
      c.state = 4'd9; c.aluSrcA = 1; c.aluSrcB = 2'b10;
      case (op)
        6'h0a:   c.aluOp = 3'b101;
        6'h0c:   c.aluOp = 3'b010;
        6'h0d:   c.aluOp = 3'b011;
        6'h0e:   c.aluOp = 3'b100;
        default: c.aluOp = 3'b000;
      endcase
      ph_q.push_back(c); mem_q.push_back(0);
      c = '0; c.state = 4'd10; c.regWrite = 1;
      ph_q.push_back(c); mem_q.push_back(0);
    end else begin
      c.state = (op == 6'h03) ? 4'd13 : 4'd12; c.pcWrite = 1; c.pcSource = 2'b10;
      if (op == 6'h03) begin c.regWrite = 1; c.regDst = 2'b10; c.memToReg = 2'b10; end
      ph_q.push_back(c); mem_q.push_back(0);
    end
  endtask

  // Runs one instruction from fetch, checking every cycle.
  // stall_n < 0: random memReady; otherwise data-memory phases wait stall_n cycles.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int stall_n);
    ctl_t want, got;
    logic mr;
    int waited;
    build_phases(op, fn);
    opcode = op; funct = fn;
    for (int i = 0; i < ph_q.size(); i++) begin
      waited = 0;
      for (int k = 0; k < 8; k++) begin
        if (mem_q[i]) begin
          if (stall_n < 0) mr = (waited >= 3) || ($urandom_range(0, 2) != 0);
          else             mr = (i == 0) || (waited >= stall_n);
        end else mr = 1'($urandom_range(0, 1));
        memReady = mr;
        #1;
        want = ph_q[i];
        if (i == 0 && mr) begin want.irWrite = 1; want.pcWrite = 1; end
        got = obs();
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s phase%0d wait%0d got=%h want=%h", name, i, waited, got, want);
        end
        @(posedge clk); #1;
        if (!mem_q[i] || mr) break;
        waited++;
        stall_model++;
      end
    end
    instr_model++;
  endtask

  task automatic release_reset(input string name);
    rst_n = 1'b1; memReady = 1'b1;
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL %s_rst_cycle got=%h want=0", name, obs());
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL %s_to_fetch state=%0d want=1", name, state);
    end
    instr_model = 0; stall_model = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", obs());
    end
    release_reset("reset");
  endtask

  task automatic test_mid_reset();
    int cyc;
    opcode = 6'h2b; funct = 6'h00; memReady = 1'b1; cyc = 0;
    while (state !== 4'd6 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    memReady = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd6 || memWrite !== 1'b1) begin
      failures++;
      $display("FAIL midrst_memwr state=%0d memWrite=%b want 6/1", state, memWrite);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs() !== '0) begin
        failures++;
        $display("FAIL midrst_hold%0d got=%h want=0", i, obs());
      end
    end
    release_reset("midrst");
  endtask

  // Cycle count from fetch back to fetch, with memReady high except read stalls
  task automatic measure(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input int rd_stall, input int lat);
    int cyc, held, waited;
    opcode = op; funct = fn; cyc = 0; held = 0; waited = 0;
    do begin
      if (state == 4'd4 && waited < rd_stall) begin
        memReady = 1'b0; waited++; stall_model++;
      end else memReady = 1'b1;
      #1;
      if (memRead && iorD) held++;
      @(posedge clk); #1;
      cyc++;
    end while (state !== 4'd1 && cyc < 30);
    instr_model++;
    checks++;
    if (cyc !== lat) begin
      failures++;
      $display("FAIL lat_%s cycles=%0d want=%0d", name, cyc, lat);
    end
    if (rd_stall > 0) begin
      checks++;
      if (held !== rd_stall + 1) begin
        failures++;
        $display("FAIL hold_%s memRead_iorD_cycles=%0d want=%0d", name, held, rd_stall + 1);
      end
    end
  endtask

  task automatic test_add();
    run_instr("add", 6'h00, 6'h20, 0);
  endtask

  task automatic test_lw_stall();
    run_instr("lw_stall", 6'h23, 6'h00, 2);
    run_instr("sw_stall", 6'h2b, 6'h00, 1);
  endtask

  task automatic test_branch();
    run_instr("bne", 6'h05, 6'h00, 0);
    run_instr("beq", 6'h04, 6'h00, 0);
  endtask

  task automatic test_jumps();
    run_instr("jal", 6'h03, 6'h00, 0);
    run_instr("jr", 6'h00, 6'h08, 0);
    run_instr("j", 6'h02, 6'h00, 0);
  endtask

  task automatic test_itype();
    run_instr("addi", 6'h08, 6'h00, 0);
    run_instr("slti", 6'h0a, 6'h00, 0);
    run_instr("andi", 6'h0c, 6'h00, 0);
    run_instr("ori", 6'h0d, 6'h00, 0);
    run_instr("xori", 6'h0e, 6'h00, 0);
  endtask

  task automatic test_illegal();
    run_instr("ill_op", 6'h3f, 6'h00, 0);
    run_instr("ill_funct", 6'h00, 6'h3f, 0);
  endtask

  task automatic test_latency();
    measure("add", 6'h00, 6'h20, 0, 4);
    measure("addi", 6'h08, 6'h00, 0, 4);
    measure("beq", 6'h04, 6'h00, 0, 3);
    measure("bne", 6'h05, 6'h00, 0, 3);
    measure("j", 6'h02, 6'h00, 0, 3);
    measure("jal", 6'h03, 6'h00, 0, 3);
    measure("jr", 6'h00, 6'h08, 0, 3);
    measure("sw", 6'h2b, 6'h00, 0, 4);
    measure("lw", 6'h23, 6'h00, 0, 5);
    measure("lw_stall2", 6'h23, 6'h00, 2, 7);
  endtask

  task automatic test_random();
    logic [5:0] pool_op [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02, 6'h03, 6'h0a};
    logic [5:0] pool_fn [6]  = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h27};
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      op = pool_op[$urandom_range(0, 9)];
      fn = pool_fn[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      run_instr("random", op, fn, -1);
    end
  endtask

`ifdef MC_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    checks++;
    if (instrCount !== 32'(instr_model)) begin
      failures++;
      $display("FAIL perf_instr got=%0d want=%0d", instrCount, instr_model);
    end
    checks++;
    if (stallCount !== 32'(stall_model)) begin
      failures++;
      $display("FAIL perf_stall got=%0d want=%0d", stallCount, stall_model);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mid_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_jumps();
    test_itype();
    test_illegal();
    test_latency();
    test_random();
`ifdef MC_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle main control FSM for the MIPS-subset datapath.
- Decodes the opcode and funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit aluOp consumed by the ALU control decoder, plus all datapath mux, enable and memory strobes.
- Stalls on a memory ready handshake.

Parameters:
- RA_REG, 31, register index written by jal (informational; selected via regDst=10).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- memReady  in  1  memory completes access this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if branch condition true
- branchNe  out  1  1 = condition is !zero (bne); 0 = zero (beq)
- iorD  out  1  memory address: 0 = PC, 1 = aluOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- irWrite  out  1  IR load
- regDst  out  2  00 rt, 01 rd, 10 RA_REG
- memToReg  out  2  00 aluOut, 01 MDR, 10 PC
- regWrite  out  1  register file write
- aluSrcA  out  1  0 = PC, 1 = A
- aluSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- pcSource  out  2  00 ALU result, 01 aluOut, 10 jump target, 11 A (jr)
- aluOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 R-type (funct decode)
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state encoding, for debug

Behaviour:
- State register is synchronous. rst_n=0 at a clock edge sets state = S_RST. In S_RST all outputs are 0; the next state is S_FETCH.
- Outputs are Moore (decoded from state), except the memReady-qualified strobes noted below. All unlisted outputs are 0 in every state.
- Reset mid-instruction: reset wins in any state. No strobe is asserted in the cycle after reset.

States and actions:
- S_FETCH (0001): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=000, pcSource=00. irWrite=pcWrite=memReady. Stay while memReady=0; go to S_DECODE when memReady=1.
- S_DECODE (0010): aluSrcA=0, aluSrcB=11, aluOp=000 (branch target into aluOut). Next state by opcode:
  - lw/sw (100011/101011) -> S_MEMADR
  - R (000000) with funct=001000 -> S_JR; other R -> S_EXEC_R
  - beq (000100) / bne (000101) -> S_BRANCH
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> S_EXEC_I
  - j (000010) -> S_JUMP; jal (000011) -> S_JAL
  - anything else: illegal=1, next S_FETCH
- S_MEMADR (0011): aluSrcA=1, aluSrcB=10, aluOp=000. lw -> S_MEMRD; sw -> S_MEMWR.
- S_MEMRD (0100): memRead=1, iorD=1. Wait for memReady=1, then S_MEMWB.
- S_MEMWB (0101): regWrite=1, regDst=00, memToReg=01; next S_FETCH.
- S_MEMWR (0110): memWrite=1, iorD=1. Wait for memReady=1, then S_FETCH.
- S_EXEC_R (0111): aluSrcA=1, aluSrcB=00, aluOp=110; next S_ALUWB_R.
  - Valid funct set: 000000, 000010, 000011, 000100, 000110, 000111, 100000, 100010, 100100, 100101, 100110, 100111, 101010, 101011.
  - Other funct: illegal=1 in S_EXEC_R, and next state is S_FETCH with no writeback.
- S_ALUWB_R (1000): regWrite=1, regDst=01, memToReg=00; next S_FETCH.
- S_EXEC_I (1001): aluSrcA=1, aluSrcB=10. aluOp by opcode: addi 000, slti 101, andi 010, ori 011, xori 100. Next S_ALUWB_I.
- S_ALUWB_I (1010): regWrite=1, regDst=00, memToReg=00; next S_FETCH.
- S_BRANCH (1011): aluSrcA=1, aluSrcB=00, aluOp=001, pcWriteCond=1, pcSource=01, branchNe=(opcode==000101); next S_FETCH.
- S_JUMP (1100): pcWrite=1, pcSource=10; next S_FETCH.
- S_JAL (1101): pcWrite=1, pcSource=10, regWrite=1, regDst=10, memToReg=10; next S_FETCH. The PC value written is the already-incremented PC.
- S_JR (1110): pcWrite=1, pcSource=11; next S_FETCH.

Latency (memReady=1 always): beq/bne/j/jal/jr 3, R/I-type 4, sw 4, lw 5 cycles. Each memReady=0 cycle adds one cycle.

Other rules:
- memRead/memWrite stay asserted and stable throughout a wait.
- opcode and funct are sampled only in S_DECODE, S_EXEC_R, S_EXEC_I, S_BRANCH and S_MEMADR; IR is stable there by construction.

Optional Feature:
- Macro MC_CTRL_PERF_CNT_EN.
- Defined: adds outputs instrCount (32) and stallCount (32). Both are cleared by reset.
  - instrCount increments on every transition into S_FETCH from a non-reset state, including illegal aborts.
  - stallCount increments on each cycle in S_FETCH/S_MEMRD/S_MEMWR with memReady=0.
  - Both wrap at 2^32-1 -> 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 three cycles in S_MEMWR -> state=S_RST, memWrite=0, all outputs 0. Release -> S_FETCH next cycle.
- add (opcode 000000, funct 100000), memReady=1: states FETCH, DECODE, EXEC_R (aluOp=110), ALUWB_R (regWrite=1, regDst=01), FETCH. 4 cycles total.
- lw with memReady low 2 cycles in S_MEMRD: memRead=1 and iorD=1 held 3 cycles; S_MEMWB gives memToReg=01; 7 cycles total.
- bne (000101): S_BRANCH has pcWriteCond=1, branchNe=1, aluOp=001, pcSource=01. beq gives branchNe=0.
- jal (000011): S_JAL has pcWrite=1, regWrite=1, regDst=10, memToReg=10, pcSource=10. jr (funct 001000) reaches S_JR with pcSource=11.
- Illegal opcode 111111 -> illegal pulse in DECODE, then FETCH with no regWrite/memWrite. R-type funct 111111 -> illegal in EXEC_R, no writeback.
